adder_cla_32bit: RTL and testbench
==================================

Name: adder_cla_32bit

Overview:
- 32-bit two's-complement/unsigned adder with carry-in and carry-out, built as a two-level carry-lookahead structure.
- The sum and carry-out are captured in an output register, giving one cycle of latency.
- Used as the base adder primitive for the VCPU-32 ALU and address-computation paths.

Parameters:
- None. The width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- a  input  [0:31]  operand A; bit 0 = MSB, bit 31 = LSB
- b  input  [0:31]  operand B; same bit order as a
- inC  input  1  carry into the LSB position (bit 31)
- s  output  [0:31]  registered sum; bit 0 = MSB
- outC  output  1  registered carry out of the MSB position (bit 0)

Behaviour:
- Function: {outC, s} = a + b + inC, computed as a 33-bit unsigned result. outC is the 33rd bit.
- Overflow detection is not provided; signed overflow is the caller's concern.
- Bit order: big-endian vectors [0:31]. Carry propagates from index 31 toward index 0.
- Lookahead structure (required, no ripple chain across groups):
  - Per bit: g = a & b, p = a ^ b.
  - Eight 4-bit CLA groups, covering bits 28-31, 24-27, ..., 0-3. Each group produces its internal carries from the group carry-in, plus a group generate G and a group propagate P.
  - A second-level lookahead unit computes all eight group carry-ins directly from inC and the group G/P terms, and also produces the final carry-out.
  - Sum per bit: s_i = p_i ^ c_i.
- Timing:
  - The combinational sum/carry is registered on the rising edge of clk.
  - s and outC reflect the a/b/inC sampled at edge N, valid after edge N.
  - Throughput is one addition per cycle. There is no handshake or enable; the register loads every cycle.
- Reset:
  - While rst is high, s = 0x00000000 and outC = 0, asynchronously (independent of clk).
  - On rst deassertion, the first load occurs at the next rising clk edge.
  - Reset asserted mid-stream clears the outputs immediately. The pending result is discarded.
- Boundary conditions:
  - 0xFFFFFFFF + 0x00000001 (inC=0): s = 0, outC = 1 (full wrap).
  - 0xFFFFFFFF + 0x00000000 with inC=1: s = 0, outC = 1 (carry-in propagates through all 32 bits).
  - 0xFFFFFFFF + 0xFFFFFFFF with inC=1: s = 0xFFFFFFFF, outC = 1 (maximum result).
  - Inputs changing between edges have no effect on outputs until the next edge.
- Implementation constraints:
  - No latches and no X propagation from reset state.
  - Fully synthesizable.

Test Plan:
- Reset: assert rst with a=0x12345678, b=1 and clocks running -> s=0x00000000, outC=0 while rst is high; after release, next edge gives s=0x12345679, outC=0.
- Basic adds, one per cycle, each checked one cycle later:
  - 0+0 (inC=0) -> s=0x00000000, outC=0
  - 10+5 -> s=0x0000000F, outC=0
  - 1+15 -> s=0x00000010, outC=0
- Wrap-around:
  - 0xFFFFFFFF+1 (inC=0) -> s=0x00000000, outC=1
  - 0xFFFFFFFF+0 with inC=1 -> s=0x00000000, outC=1
  - 0xFFFFFFFF+0xFFFFFFFF with inC=1 -> s=0xFFFFFFFF, outC=1
- Group boundaries: 0x0000000F+1 -> 0x00000010; 0x0FFFFFFF+1 -> 0x10000000, outC=0; 0x7FFFFFFF+1 -> 0x80000000, outC=0. Checks inter-group carries.
- Back-to-back pipeline: change operands every cycle over 1000 random vectors (random inC); each result matches the 33-bit reference sum of the previous cycle's inputs.
- Async reset mid-operation: assert rst between clock edges -> outputs go to 0 before the next edge; a result captured before reset is not seen after release.

Source files
------------

// File: rtl/adder_cla_32bit.sv
// 32-bit adder with carry-in/carry-out, two-level carry lookahead, registered result.
// Vectors are big-endian: index 0 is the MSB, index 31 the LSB; carries flow 31 -> 0.
module adder_cla_32bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:31] a,
   input  logic [0:31] b,
   input  logic        inC,
   output logic [0:31] s,
   output logic        outC
);

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned GRP_W   = 4;
   localparam int unsigned NUM_GRP = WIDTH / GRP_W;

   logic [0:WIDTH-1]   g;
   logic [0:WIDTH-1]   p;
   logic [0:WIDTH-1]   c;
   logic [0:WIDTH-1]   sum_c;
   // Group terms use little-endian group numbering: group 0 covers bits 28-31.
   logic [NUM_GRP-1:0] grp_g;
   logic [NUM_GRP-1:0] grp_p;
   logic [NUM_GRP:0]   grp_c;
   logic               prod;
   logic               acc;

   // Per-bit generate and propagate.
   assign g = a & b;
   assign p = a ^ b;

   // First level: eight 4-bit lookahead groups, internal carries from group carry-in.
   for (genvar q = 0; q < NUM_GRP; q++) begin : g_grp
      localparam int unsigned B0 = WIDTH - 1 - GRP_W * q;
      localparam int unsigned B1 = B0 - 1;
      localparam int unsigned B2 = B0 - 2;
      localparam int unsigned B3 = B0 - 3;

      logic ci;
      assign ci = grp_c[q];

      assign c[B0] = ci;
      assign c[B1] = g[B0] | (p[B0] & ci);
      assign c[B2] = g[B1] | (p[B1] & g[B0]) | (p[B1] & p[B0] & ci);
      assign c[B3] = g[B2] | (p[B2] & g[B1]) | (p[B2] & p[B1] & g[B0])
                   | (p[B2] & p[B1] & p[B0] & ci);

      assign grp_g[q] = g[B3] | (p[B3] & g[B2]) | (p[B3] & p[B2] & g[B1])
                      | (p[B3] & p[B2] & p[B1] & g[B0]);
      assign grp_p[q] = p[B3] & p[B2] & p[B1] & p[B0];
   end

   // Second level: every group carry-in (and the final carry-out) as a flat sum of
   // products of inC and the group G/P terms, so no carry ripples between groups.
   always_comb begin
      grp_c    = '0;
      prod     = 1'b0;
      acc      = 1'b0;
      grp_c[0] = inC;
      for (int q = 1; q <= int'(NUM_GRP); q++) begin
         acc = 1'b0;
         for (int m = -1; m < q; m++) begin
            prod = (m < 0) ? inC : grp_g[3'(m)];
            for (int n = m + 1; n < q; n++) begin
               prod = prod & grp_p[3'(n)];
            end
            acc = acc | prod;
         end
         grp_c[4'(q)] = acc;
      end
   end

   // Per-bit sum.
   assign sum_c = p ^ c;

   // Output register; reset clears the result asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s    <= '0;
         outC <= 1'b0;
      end else begin
         s    <= sum_c;
         outC <= grp_c[NUM_GRP];
      end
   end

endmodule

// File: tb/tb_adder_cla_32bit.sv
// Scoreboard bench for adder_cla_32bit: driver pushes reference sums, monitor pops and compares.
module tb_adder_cla_32bit;

   logic        clk;
   logic        rst;
   logic [0:31] a;
   logic [0:31] b;
   logic        inC;
   logic [0:31] s;
   logic        outC;

   logic [32:0] exp_q[$];
   int          n_checks;
   int          n_pass;
   logic        drive_done;

   adder_cla_32bit dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .inC  (inC),
      .s    (s),
      .outC (outC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain 33-bit unsigned addition.
   function automatic logic [32:0] ref_sum(input logic [31:0] av, input logic [31:0] bv,
                                           input logic ci);
      return {1'b0, av} + {1'b0, bv} + 33'(ci);
   endfunction

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got outC=%0b s=%08h, expected outC=%0b s=%08h",
                    name, act[32], act[31:0], exp[32], exp[31:0]);
   endtask

   // Apply operands just after a falling edge and record the sum they must produce.
   task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic ci);
      @(negedge clk);
      a   = av;
      b   = bv;
      inC = ci;
      exp_q.push_back(ref_sum(av, bv, ci));
   endtask

   // Monitor: every capture edge presents one result; compare against the oldest expectation.
   always @(posedge clk) begin
      logic [32:0] e;
      #1;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pipe", {outC, s}, e);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [32:0] held;
      n_checks   = 0;
      n_pass     = 0;
      drive_done = 1'b0;

      // Reset with live operands and running clock.
      rst = 1'b1;
      a   = 32'h1234_5678;
      b   = 32'h0000_0001;
      inC = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", {outC, s}, 33'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(ref_sum(32'h1234_5678, 32'h0000_0001, 1'b0));

      // Basic adds.
      drive(32'd0, 32'd0, 1'b0);
      drive(32'd10, 32'd5, 1'b0);
      drive(32'd1, 32'd15, 1'b0);
      // Wrap-around.
      drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      // Group boundaries.
      drive(32'h0000_000F, 32'h0000_0001, 1'b0);
      drive(32'h0FFF_FFFF, 32'h0000_0001, 1'b0);
      drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      drive(32'h0000_FFFF, 32'h0000_0000, 1'b1);

      // Inputs changed between edges must not disturb the held result.
      drive(32'hDEAD_BEEF, 32'h0102_0304, 1'b1);
      held = ref_sum(32'hDEAD_BEEF, 32'h0102_0304, 1'b1);
      @(posedge clk);
      #3;
      a   = 32'h5555_5555;
      b   = 32'hAAAA_AAAA;
      inC = 1'b1;
      #1;
      check("hold_between_edges", {outC, s}, held);

      // Back-to-back random vectors.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         drive(ra, rb, 1'($urandom_range(0, 1)));
      end

      // Async reset between edges discards the captured result.
      drive(32'h8000_0000, 32'h8000_0001, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset_clear", {outC, s}, 33'h0);
      a   = 32'h0000_1111;
      b   = 32'h0000_2222;
      inC = 1'b0;
      @(posedge clk);
      #1;
      check("reset_during_edge", {outC, s}, 33'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("after_release_pre_edge", {outC, s}, 33'h0);
      exp_q.push_back(ref_sum(32'h0000_1111, 32'h0000_2222, 1'b0));
      drive(32'hFFFF_0000, 32'h0001_0000, 1'b0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
      end
      drive_done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
